or_out_change_logger: RTL and testbench
=======================================

// Module: or_out_change_logger
// PURPOSE
// - Sits directly downstream of the OR gate and consumes its y bus.
// - Samples y every enabled cycle and detects any change against the previous sample.
// - Each change is stamped with a free-running cycle counter and queued in a small FIFO.
// - A consumer drains the FIFO over a valid/ready handshake.
// PARAMETERS
// - WIDTH     8   width of the y bus (matches the OR_out bus width)
// - DEPTH     4   FIFO entries; power of 2, >= 2
// - TS_WIDTH  16  timestamp counter width
// PORTS
// - clk        in   1                  single clock; all logic on rising edge
// - rst        in   1                  synchronous, active-low reset
// - en         in   1                  sampling/timestamp enable
// - y          in   WIDTH              OR gate output bus being observed
// - evt_valid  out  1                  FIFO head holds an event
// - evt_ready  in   1                  consumer accepts head when evt_valid=1
// - evt_data   out  WIDTH              y value of head event
// - evt_ts     out  TS_WIDTH           timestamp of head event
// - evt_count  out  $clog2(DEPTH)+1    entries currently queued (0..DEPTH)
// - overflow   out  1                  sticky: an event was dropped
// BEHAVIOUR
// - Reset (rst=0 at a clk edge):
//   - y_q, ts, FIFO pointers, evt_count and overflow all go to 0.
//   - evt_valid=0; evt_data/evt_ts=0.
// - Timestamp: ts increments by 1 on every clk edge with en=1. It wraps 2^TS_WIDTH-1 -> 0 silently and holds when en=0.
// - Change detect:
//   - change = en & (y != y_q).
//   - y_q <= y only when en=1, so the first enabled sample after reset is compared against 0.
// - Push on change writes {y, ts} into the FIFO.
//   - ts is the pre-increment value for that edge.
//   - Example: y changes in the cycle where ts reads 5, so the event carries ts=5.
// - Latency: an event whose change is sampled at edge N shows evt_valid=1 immediately after edge N (1 cycle).
// - FIFO is show-ahead:
//   - evt_valid = (evt_count != 0).
//   - evt_data/evt_ts always present the head entry.
//   - Pop occurs when evt_valid & evt_ready at a clk edge.
//   - evt_ready while evt_valid=0 has no effect.
// - Simultaneous push + pop:
//   - count unchanged, both pointers advance.
//   - Legal when full: the pop frees the slot and the push is accepted.
//   - Legal when empty-but-pushing: no pop occurs since evt_valid=0.
// - Full and push without pop:
//   - The new event is dropped and overflow <= 1.
//   - FIFO contents are untouched.
// - overflow clears only on reset.
// - Pointers are $clog2(DEPTH) bits and wrap naturally. evt_count is the authoritative full/empty indicator.
// - evt_data/evt_ts must be stable while evt_valid=1 and evt_ready=0.
// - Reset mid-operation discards all queued events in the same edge. The next event can be pushed on the first edge after rst returns high.
// - y is treated as synchronous to clk; no synchronizer inside.
// TESTING
// - T1 reset: rst=0 for 2 cycles with y=8'hFF
//   -> evt_valid=0, evt_count=0, overflow=0, evt_data=0.
// - T2 single change: rst=1, en=1, evt_ready=0; y 0 -> 8'h0F at ts=3
//   -> next cycle evt_valid=1, evt_data=8'h0F, evt_ts=3, evt_count=1.
// - T3 no change: y held at 8'h0F for 10 cycles
//   -> evt_count stays 1 and ts advances by 10.
// - T4 overflow: evt_ready=0, DEPTH=4; y toggles 8'h01,02,03,04,05 on consecutive cycles
//   -> evt_count=4, overflow=1; entries read back 01..04 with consecutive ts.
// - T5 push+pop at full: FIFO full, evt_ready=1 and y changes the same cycle
//   -> evt_count stays 4, overflow unchanged, head advances.
// - T6 en gating: en=0 while y changes 8'hAA -> 8'h55
//   -> no event and ts frozen; en=1 -> one event with evt_data=8'h55.
// - T7 wrap + mid reset: TS_WIDTH=4, run 20 enabled cycles
//   -> ts wraps 15 -> 0; then rst=0 with 3 queued -> evt_count=0 next cycle.

Source files
------------

// File: rtl/or_out_change_logger.sv
// ---------------------------------------------------------------------------
// or_out_change_logger
//
// Watches the OR gate output bus y. It samples y on every enabled cycle and
// compares it with the previous sample. Each change is stamped with a
// free-running cycle counter and queued in a small show-ahead FIFO. A
// consumer drains the FIFO over a valid/ready handshake.
//
// Ports
//   clk        in   1               single rising-edge clock
//   rst        in   1               synchronous reset, active low
//   en         in   1               sampling / timestamp enable
//   y          in   WIDTH           observed OR gate output bus
//   evt_valid  out  1               FIFO head holds an event
//   evt_ready  in   1               consumer accepts the head when evt_valid=1
//   evt_data   out  WIDTH           y value of the head event (0 when empty)
//   evt_ts     out  TS_WIDTH        timestamp of the head event (0 when empty)
//   evt_count  out  $clog2(DEPTH)+1 number of queued entries, 0..DEPTH
//   overflow   out  1               sticky flag: an event was dropped
// ---------------------------------------------------------------------------
module or_out_change_logger #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           y,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [WIDTH-1:0]           evt_data,
  output logic [TS_WIDTH-1:0]        evt_ts,
  output logic [$clog2(DEPTH):0]     evt_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0]    y_q, y_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;

  logic [WIDTH-1:0]    data_mem [DEPTH];
  logic [TS_WIDTH-1:0] ts_mem   [DEPTH];

  logic change, pop, full, push_ok;

  always_comb begin
    change  = en && (y != y_q);
    pop     = (count_q != '0) && evt_ready;
    full    = (count_q == CW'(DEPTH));
    // A pop in the same edge frees a slot, so a full FIFO still accepts.
    push_ok = change && (!full || pop);

    y_d     = en ? y : y_q;
    ts_d    = en ? ts_q + TS_WIDTH'(1) : ts_q;
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    ovf_d   = ovf_q || (change && !push_ok);

    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      y_q     <= '0;
      ts_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      ts_q    <= ts_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage carries data only; validity is governed entirely by count_q,
  // so the array needs no reset. The stamp is the pre-increment ts_q.
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      data_mem[wr_q] <= y;
      ts_mem[wr_q]   <= ts_q;
    end
  end

  // Head is forced to zero while empty so reset and drained states read 0.
  assign evt_valid = (count_q != '0);
  assign evt_data  = evt_valid ? data_mem[rd_q] : '0;
  assign evt_ts    = evt_valid ? ts_mem[rd_q]   : '0;
  assign evt_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_or_out_change_logger.sv
module tb_or_out_change_logger;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, en, evt_ready;
  logic [WIDTH-1:0] y;

  logic             v_a, v_b, o_a, o_b;
  logic [7:0]       d_a, d_b;
  logic [15:0]      t_a;
  logic [3:0]       t_b;
  logic [2:0]       c_a, c_b;

  int checks = 0;
  int fails  = 0;

  // Model state: a plain queue of events plus a cycle counter.
  logic [7:0] mq_d [$];
  int         mq_t [$];
  int         m_ts;
  logic [7:0] m_yq;
  logic       m_ovf;

  always #5 clk = ~clk;

  or_out_change_logger #(.WIDTH(8), .DEPTH(4), .TS_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .y(y),
    .evt_valid(v_a), .evt_ready(evt_ready), .evt_data(d_a), .evt_ts(t_a),
    .evt_count(c_a), .overflow(o_a)
  );

  or_out_change_logger #(.WIDTH(8), .DEPTH(4), .TS_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .y(y),
    .evt_valid(v_b), .evt_ready(evt_ready), .evt_data(d_b), .evt_ts(t_b),
    .evt_count(c_b), .overflow(o_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the event-log rules.
  always @(posedge clk) begin
    bit have_pop, chg;
    if (!rst) begin
      mq_d.delete(); mq_t.delete();
      m_ts = 0; m_yq = '0; m_ovf = 1'b0;
    end else begin
      have_pop = (mq_d.size() != 0) && evt_ready;
      chg      = en && (y != m_yq);
      if (have_pop) begin
        void'(mq_d.pop_front()); void'(mq_t.pop_front());
      end
      if (chg) begin
        if (mq_d.size() == DEPTH) m_ovf = 1'b1;
        else begin mq_d.push_back(y); mq_t.push_back(m_ts); end
      end
      if (en) begin m_yq = y; m_ts = m_ts + 1; end
    end
  end

  always @(negedge clk) begin
    logic [7:0] ed;
    int et;
    ed = (mq_d.size() != 0) ? mq_d[0] : 8'h00;
    et = (mq_t.size() != 0) ? mq_t[0] : 0;
    check("a_valid", {31'd0, v_a}, {31'd0, mq_d.size() != 0});
    check("a_count", {29'd0, c_a}, mq_d.size());
    check("a_ovf",   {31'd0, o_a}, {31'd0, m_ovf});
    check("a_data",  {24'd0, d_a}, {24'd0, ed});
    check("a_ts",    {16'd0, t_a}, et & 32'hFFFF);
    check("b_valid", {31'd0, v_b}, {31'd0, mq_d.size() != 0});
    check("b_count", {29'd0, c_b}, mq_d.size());
    check("b_ovf",   {31'd0, o_b}, {31'd0, m_ovf});
    check("b_data",  {24'd0, d_b}, {24'd0, ed});
    check("b_ts",    {28'd0, t_b}, et & 32'hF);
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; evt_ready = 1'b0; y = 8'hFF;

    // T1 reset
    step(2);
    check("t1_valid", {31'd0, v_a}, 0);
    check("t1_count", {29'd0, c_a}, 0);
    check("t1_ovf",   {31'd0, o_a}, 0);
    check("t1_data",  {24'd0, d_a}, 0);

    // T2 single change at ts=3
    rst = 1'b1; y = 8'h00;
    step(3);
    y = 8'h0F;
    step(1);
    check("t2_valid", {31'd0, v_a}, 1);
    check("t2_data",  {24'd0, d_a}, 32'h0F);
    check("t2_ts",    {16'd0, t_a}, 3);
    check("t2_count", {29'd0, c_a}, 1);

    // T3 no change for 10 cycles
    step(10);
    check("t3_count", {29'd0, c_a}, 1);
    check("t3_ts",    {16'd0, t_a}, 3);

    // Drain, then T4 overflow: five changes, ts 15..19
    evt_ready = 1'b1; step(1);
    check("t4_empty", {29'd0, c_a}, 0);
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      y = 8'(i); step(1);
    end
    check("t4_count", {29'd0, c_a}, 4);
    check("t4_ovf",   {31'd0, o_a}, 1);
    check("t4_head",  {24'd0, d_a}, 32'h01);
    check("t4_hts",   {16'd0, t_a}, 15);

    // T5 push+pop at full: event 06 at ts=20
    evt_ready = 1'b1; y = 8'h06; step(1);
    check("t5_count", {29'd0, c_a}, 4);
    check("t5_ovf",   {31'd0, o_a}, 1);
    check("t5_head",  {24'd0, d_a}, 32'h02);
    check("t5_hts",   {16'd0, t_a}, 16);
    step(1); check("t5_rd3", {24'd0, d_a}, 32'h03);
    check("t5_ts3", {16'd0, t_a}, 17);
    step(1); check("t5_rd4", {24'd0, d_a}, 32'h04);
    check("t5_ts4", {16'd0, t_a}, 18);
    step(1); check("t5_rd6", {24'd0, d_a}, 32'h06);
    check("t5_ts6", {16'd0, t_a}, 20);
    step(1); check("t5_drained", {29'd0, c_a}, 0);
    evt_ready = 1'b0;

    // T6 en gating: ts frozen at 25
    en = 1'b0; y = 8'hAA; step(2);
    y = 8'h55; step(1);
    check("t6_none", {29'd0, c_a}, 0);
    en = 1'b1; step(1);
    check("t6_count", {29'd0, c_a}, 1);
    check("t6_data",  {24'd0, d_a}, 32'h55);
    check("t6_ts",    {16'd0, t_a}, 25);

    // T7 wrap in the 4-bit counter (25 mod 16) and mid-operation reset
    check("t7_wrap",  {28'd0, t_b}, 9);
    y = 8'h56; step(1);
    y = 8'h57; step(1);
    check("t7_q3",    {29'd0, c_b}, 3);
    rst = 1'b0; step(1);
    check("t7_rst_cnt", {29'd0, c_b}, 0);
    check("t7_rst_vld", {31'd0, v_b}, 0);
    check("t7_rst_ovf", {31'd0, o_a}, 0);
    rst = 1'b1; y = 8'h58; step(1);
    check("t7_post_cnt", {29'd0, c_b}, 1);
    check("t7_post_ts",  {28'd0, t_b}, 0);
    check("t7_post_dat", {24'd0, d_b}, 32'h58);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
